// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } state_e;

  localparam int ADDR_W_DEF  = 18;
  localparam int DATA_W_DEF  = 16;
  localparam int ACC_CYC_DEF = 2;

  localparam logic [1:0] BE_INACTIVE = 2'b11;

endpackage

// File: rtl/sram_arb_sched.sv
// Display/host grant selection. Defining SRAM_ARB_STARVE_GUARD_EN adds a
// display-run counter that hands one accept cycle to the host after MAX_DISP_RUN display grants.
module sram_arb_sched
  import sram_arb_pkg::*;
#(
  parameter int MAX_DISP_RUN = 8
)(
  input  logic Clk,
  input  logic Rst,
  input  logic accept,
  input  logic disp_req,
  input  logic host_req,
  output logic disp_gnt,
  output logic host_gnt
);

  logic host_first;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int RUN_W = (MAX_DISP_RUN < 1) ? 1 : $clog2(MAX_DISP_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DISP_RUN);

  logic [RUN_W-1:0] run_cnt;

  assign host_first = host_req && (run_cnt == RUN_MAX);

  // Saturates at RUN_MAX; any host grant restarts the run.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      run_cnt <= '0;
    end else if (host_gnt) begin
      run_cnt <= '0;
    end else if (disp_gnt && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{Clk, Rst, MAX_DISP_RUN[0]};
  assign host_first = 1'b0;
`endif

  assign disp_gnt = accept && disp_req && !host_first;
  assign host_gnt = accept && host_req && (!disp_req || host_first);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a display read port and a host read/write port onto one async SRAM.
// Optional starvation guard: define SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ACC_CYC      = ACC_CYC_DEF,
  parameter int MAX_DISP_RUN = 8
)(
  input  logic              Clk,
  input  logic              Rst,
  // display read port
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  // host port
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_be,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_wdone,
  // SRAM side
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [1:0]        SRAM_BE,
  output logic              SRAM_NCE,
  output logic              SRAM_NOE,
  output logic              SRAM_NWE,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  state_e     state, state_nxt;
  logic [3:0] acc_cnt, acc_nxt;
  logic       last, accept, owner_host;

  assign last   = (acc_cnt == 4'(ACC_CYC - 1));
  assign accept = !Rst && ((state == IDLE) || ((state == RD) && last));

  sram_arb_sched #(
    .MAX_DISP_RUN (MAX_DISP_RUN)
  ) u_sched (
    .Clk      (Clk),
    .Rst      (Rst),
    .accept   (accept),
    .disp_req (disp_req),
    .host_req (host_req),
    .disp_gnt (disp_gnt),
    .host_gnt (host_gnt)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = '0;
    case (state)
      IDLE: state_nxt = IDLE;
      RD: begin
        if (last) state_nxt = IDLE;
        else      acc_nxt   = acc_cnt + 4'd1;
      end
      WR: begin
        if (last) state_nxt = TURN;
        else      acc_nxt   = acc_cnt + 4'd1;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A grant only happens in an accept cycle, so it overrides the default path.
    if (disp_gnt || (host_gnt && !host_we)) begin
      state_nxt = RD;
    end else if (host_gnt) begin
      state_nxt = WR;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      acc_cnt     <= '0;
      owner_host  <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_BE     <= BE_INACTIVE;
      SRAM_NCE    <= 1'b1;
      SRAM_NOE    <= 1'b1;
      SRAM_NWE    <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      host_wdone  <= 1'b0;
      disp_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      acc_cnt     <= acc_nxt;
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      host_wdone  <= (state == WR) && last;

      // Read data is captured on the edge that closes the final RD cycle.
      if ((state == RD) && last) begin
        if (owner_host) begin
          host_rvalid <= 1'b1;
          host_rdata  <= sram_dq_in;
        end else begin
          disp_rvalid <= 1'b1;
          disp_rdata  <= sram_dq_in;
        end
      end

      // NOE stays high whenever the arbiter drives the bus.
      case (state_nxt)
        RD: begin
          SRAM_NCE   <= 1'b0;
          SRAM_NOE   <= 1'b0;
          SRAM_NWE   <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        WR: begin
          SRAM_NCE   <= 1'b0;
          SRAM_NOE   <= 1'b1;
          SRAM_NWE   <= 1'b0;
          sram_dq_oe <= 1'b1;
        end
        default: begin
          SRAM_NCE   <= 1'b1;
          SRAM_NOE   <= 1'b1;
          SRAM_NWE   <= 1'b1;
          sram_dq_oe <= 1'b0;
          SRAM_BE    <= BE_INACTIVE;
        end
      endcase

      if (disp_gnt) begin
        owner_host <= 1'b0;
        SRAM_ADDR  <= disp_addr;
        SRAM_BE    <= 2'b00;
      end else if (host_gnt) begin
        owner_host <= 1'b1;
        SRAM_ADDR  <= host_addr;
        SRAM_BE    <= ~host_be;
        if (host_we) sram_dq_out <= host_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM and a shadow-memory reference.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int ACC    = 2;
  localparam int MAXRUN = 8;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Rst;
  logic              disp_req, disp_gnt, disp_rvalid;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              host_req, host_we, host_gnt, host_rvalid, host_wdone;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic [1:0]        host_be;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [1:0]        SRAM_BE;
  logic              SRAM_NCE, SRAM_NOE, SRAM_NWE, sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_out, sram_dq_in;

  int checks = 0;
  int errors = 0;
  int bus_clash = 0;
  int run_model = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 Clk = ~Clk;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(ACC), .MAX_DISP_RUN(MAXRUN)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_be(host_be), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_wdone(host_wdone),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_BE(SRAM_BE), .SRAM_NCE(SRAM_NCE),
    .SRAM_NOE(SRAM_NOE), .SRAM_NWE(SRAM_NWE), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  // Async SRAM: drives data while selected and output-enabled, writes enabled bytes.
  assign sram_dq_in = (!SRAM_NCE && !SRAM_NOE) ? mem[SRAM_ADDR] : 16'h0BAD;

  always @(posedge Clk) begin
    if (!SRAM_NCE && !SRAM_NWE) begin
      if (!SRAM_BE[1]) mem[SRAM_ADDR][15:8] <= sram_dq_out[15:8];
      if (!SRAM_BE[0]) mem[SRAM_ADDR][7:0]  <= sram_dq_out[7:0];
    end
  end

  always @(negedge Clk) begin
    if (sram_dq_oe && !SRAM_NOE) bus_clash <= bus_clash + 1;
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int next_run(input int run, input bit host_won);
    if (host_won) return 0;
    return (run < MAXRUN) ? run + 1 : MAXRUN;
  endfunction

  task automatic test_reset();
    Rst = 1'b1; disp_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
    tick(); tick(); settle();
    checks++;
    if (disp_gnt !== 1'b0 || host_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt disp=%b host=%b expected 0 0", disp_gnt, host_gnt);
    end
    checks++;
    if ({SRAM_NCE, SRAM_NOE, SRAM_NWE} !== 3'b111) begin
      errors++; $display("FAIL reset_ctl got %b expected 111", {SRAM_NCE, SRAM_NOE, SRAM_NWE});
    end
    checks++;
    if (SRAM_BE !== 2'b11 || SRAM_ADDR !== '0) begin
      errors++; $display("FAIL reset_be_addr be=%b addr=%h expected 11 0", SRAM_BE, SRAM_ADDR);
    end
    checks++;
    if (sram_dq_oe !== 1'b0 || sram_dq_out !== '0) begin
      errors++; $display("FAIL reset_dq oe=%b out=%h expected 0 0", sram_dq_oe, sram_dq_out);
    end
    checks++;
    if ({disp_rvalid, host_rvalid, host_wdone} !== 3'b000 || disp_rdata !== '0 || host_rdata !== '0) begin
      errors++; $display("FAIL reset_status flags=%b drd=%h hrd=%h expected 000 0 0",
                         {disp_rvalid, host_rvalid, host_wdone}, disp_rdata, host_rdata);
    end
    disp_req = 1'b0; host_req = 1'b0; Rst = 1'b0; run_model = 0;
  endtask

  task automatic test_disp_read();
    mem[18'h00010] <= 16'hA5C3;
    tick(); disp_req = 1'b1; disp_addr = 18'h00010; settle();
    checks++;
    if (disp_gnt !== 1'b1) begin errors++; $display("FAIL dread_gnt got %b expected 1", disp_gnt); end
    for (int c = 1; c <= ACC; c++) begin
      tick(); disp_req = 1'b0; settle();
      checks++;
      if ({SRAM_NCE, SRAM_NOE, SRAM_NWE, SRAM_BE} !== 5'b00100 || SRAM_ADDR !== 18'h00010) begin
        errors++; $display("FAIL dread_cyc%0d ctl=%b addr=%h expected 00100 00010", c,
                           {SRAM_NCE, SRAM_NOE, SRAM_NWE, SRAM_BE}, SRAM_ADDR);
      end
    end
    tick(); settle();
    checks++;
    if (disp_rvalid !== 1'b1 || disp_rdata !== 16'hA5C3 || host_rvalid !== 1'b0) begin
      errors++; $display("FAIL dread_rvalid v=%b d=%h hv=%b expected 1 a5c3 0", disp_rvalid, disp_rdata, host_rvalid);
    end
    checks++;
    if (SRAM_NCE !== 1'b1) begin errors++; $display("FAIL dread_idle nce=%b expected 1", SRAM_NCE); end
    tick(); settle();
    checks++;
    if (disp_rvalid !== 1'b0 || disp_rdata !== 16'hA5C3) begin
      errors++; $display("FAIL dread_hold v=%b d=%h expected 0 a5c3", disp_rvalid, disp_rdata);
    end
  endtask

  task automatic test_host_write();
    mem[18'h3FFFF] <= 16'hBEEF;
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h3FFFF; host_wdata = 16'h1234; host_be = 2'b10;
    settle();
    checks++;
    if (host_gnt !== 1'b1 || disp_gnt !== 1'b0) begin
      errors++; $display("FAIL hwrite_gnt host=%b disp=%b expected 1 0", host_gnt, disp_gnt);
    end
    for (int c = 1; c <= ACC; c++) begin
      tick(); host_req = 1'b0; settle();
      checks++;
      if ({SRAM_NCE, SRAM_NOE, SRAM_NWE} !== 3'b010 || SRAM_BE !== 2'b01 || sram_dq_oe !== 1'b1 ||
          sram_dq_out !== 16'h1234 || SRAM_ADDR !== 18'h3FFFF) begin
        errors++; $display("FAIL hwrite_cyc%0d ctl=%b be=%b oe=%b out=%h addr=%h expected 010 01 1 1234 3ffff",
                           c, {SRAM_NCE, SRAM_NOE, SRAM_NWE}, SRAM_BE, sram_dq_oe, sram_dq_out, SRAM_ADDR);
      end
    end
    tick(); host_we = 1'b0; settle();
    checks++;
    if (host_wdone !== 1'b1 || {SRAM_NCE, SRAM_NOE, SRAM_NWE} !== 3'b111 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL hwrite_turn wdone=%b ctl=%b oe=%b expected 1 111 0",
                         host_wdone, {SRAM_NCE, SRAM_NOE, SRAM_NWE}, sram_dq_oe);
    end
    tick(); settle();
    checks++;
    if (host_wdone !== 1'b0) begin errors++; $display("FAIL hwrite_wdone_pulse got %b expected 0", host_wdone); end
    checks++;
    if (mem[18'h3FFFF] !== 16'h12EF) begin
      errors++; $display("FAIL hwrite_mem got %h expected 12ef", mem[18'h3FFFF]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [3];
    int gcyc [3];
    int ng, nv, nce_low;
    bit g;
    ng = 0; nv = 0; nce_low = 0;
    for (int i = 0; i < 3; i++) begin
      exp_d[i] = 16'($urandom);
      mem[18'h100 + 18'(i)] <= exp_d[i];
      gcyc[i] = -100;
    end
    tick(); disp_req = 1'b1; disp_addr = 18'h100; settle();
    for (int c = 0; c < 4 * ACC + 6; c++) begin
      if (disp_gnt) begin
        if (ng < 3) gcyc[ng] = c;
        ng++;
      end
      if (!SRAM_NCE) nce_low++;
      if (disp_rvalid) begin
        if (nv < 3) begin
          checks++;
          if (disp_rdata !== exp_d[nv]) begin
            errors++; $display("FAIL b2b_data%0d got %h expected %h", nv, disp_rdata, exp_d[nv]);
          end
        end
        nv++;
      end
      g = disp_gnt;
      tick();
      if (g) begin
        if (ng >= 3) disp_req = 1'b0;
        else disp_addr = 18'h100 + 18'(ng);
      end
      settle();
    end
    disp_req = 1'b0;
    checks++;
    if (ng != 3) begin errors++; $display("FAIL b2b_grants got %0d expected 3", ng); end
    checks++;
    if (gcyc[1] - gcyc[0] != ACC || gcyc[2] - gcyc[1] != ACC) begin
      errors++; $display("FAIL b2b_spacing got %0d %0d expected %0d", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1], ACC);
    end
    checks++;
    if (nce_low != 3 * ACC) begin errors++; $display("FAIL b2b_nce_low got %0d expected %0d", nce_low, 3 * ACC); end
    checks++;
    if (nv != 3) begin errors++; $display("FAIL b2b_rvalids got %0d expected 3", nv); end
  endtask

  task automatic test_write_then_read();
    logic [15:0] d, rd;
    int last_nwe, first_noe, nturn;
    bit got, g;
    d = 16'($urandom); rd = '0;
    last_nwe = -100; first_noe = -100; nturn = 0; got = 1'b0; g = 1'b0;
    mem[18'h00200] <= 16'h0000;
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00200; host_wdata = d; host_be = 2'b11;
    settle();
    checks++;
    if (host_gnt !== 1'b1) begin errors++; $display("FAIL wtr_host_gnt got %b expected 1", host_gnt); end
    for (int c = 1; c < 20; c++) begin
      tick();
      host_req = 1'b0; host_we = 1'b0;
      if (c == 1) begin disp_req = 1'b1; disp_addr = 18'h00200; end
      else if (g) disp_req = 1'b0;
      settle();
      if (!SRAM_NWE) last_nwe = c;
      if (!SRAM_NOE && first_noe < 0) first_noe = c;
      if (host_wdone) nturn++;
      if (disp_rvalid) begin got = 1'b1; rd = disp_rdata; end
      g = disp_gnt;
    end
    disp_req = 1'b0;
    checks++;
    if (first_noe - last_nwe != 3) begin
      errors++; $display("FAIL wtr_gap got %0d expected 3 (write end to read start)", first_noe - last_nwe);
    end
    checks++;
    if (nturn != 1) begin errors++; $display("FAIL wtr_turns got %0d expected 1", nturn); end
    checks++;
    if (!got || rd !== d) begin errors++; $display("FAIL wtr_data got %h valid=%b expected %h", rd, got, d); end
    checks++;
    if (bus_clash != 0) begin errors++; $display("FAIL bus_clash got %0d expected 0", bus_clash); end
  endtask

  task automatic test_random();
    logic [17:0] pool [8];
    logic [15:0] shadow [8];
    logic [15:0] d, rd;
    logic [1:0]  be;
    int kind, idx, lat, nce, wrong;
    bit exp_host, done;
    tick(); Rst = 1'b1; tick(); Rst = 1'b0; run_model = 0;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 18'h20000 | 18'(i << 8) | 18'($urandom_range(0, 255));
      shadow[i] = 16'($urandom);
      mem[pool[i]] <= shadow[i];
    end
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, 7);
      d    = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      tick();
      disp_req = (kind == 0 || kind == 3); disp_addr = pool[idx];
      host_req = (kind != 0); host_we = (kind == 2);
      host_addr = pool[idx]; host_wdata = d; host_be = be;
      settle();
      exp_host = (kind == 1 || kind == 2) || (kind == 3 && GUARD && run_model == MAXRUN);
      checks++;
      if (host_gnt !== exp_host || disp_gnt !== !exp_host) begin
        errors++; $display("FAIL rnd%0d_gnt kind=%0d disp=%b host=%b expected host=%b", t, kind, disp_gnt, host_gnt, exp_host);
      end
      run_model = next_run(run_model, exp_host);
      lat = 0; nce = 0; wrong = 0; done = 1'b0;
      while (!done && lat < 4 * ACC + 4) begin
        tick(); disp_req = 1'b0; host_req = 1'b0; host_we = 1'b0; settle();
        lat++;
        if (!SRAM_NCE) nce++;
        if (exp_host ? disp_rvalid : (host_rvalid || host_wdone)) wrong++;
        if (exp_host ? (kind == 2 ? host_wdone : host_rvalid) : disp_rvalid) done = 1'b1;
      end
      checks++;
      if (!done || lat != ACC + 1 || wrong != 0) begin
        errors++; $display("FAIL rnd%0d_done done=%b lat=%0d stray=%0d expected 1 %0d 0", t, done, lat, wrong, ACC + 1);
      end
      checks++;
      if (nce != ACC) begin errors++; $display("FAIL rnd%0d_nce got %0d expected %0d", t, nce, ACC); end
      if (kind == 2) begin
        shadow[idx] = {be[1] ? d[15:8] : shadow[idx][15:8], be[0] ? d[7:0] : shadow[idx][7:0]};
      end else begin
        rd = exp_host ? host_rdata : disp_rdata;
        checks++;
        if (rd !== shadow[idx]) begin errors++; $display("FAIL rnd%0d_data got %h expected %h", t, rd, shadow[idx]); end
      end
    end
    tick(); settle();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[pool[i]] !== shadow[i]) begin
        errors++; $display("FAIL rnd_mem%0d got %h expected %h", i, mem[pool[i]], shadow[i]);
      end
    end
  endtask

  task automatic test_starve();
    int ng, nh, c;
    bit exp_host;
    tick(); Rst = 1'b1; tick(); Rst = 1'b0; run_model = 0;
    disp_req = 1'b1; disp_addr = 18'h00300;
    host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00301; host_be = 2'b11;
    settle();
    ng = 0; nh = 0; c = 0;
    while (ng < 27 && c < 200) begin
      if (disp_gnt || host_gnt) begin
        exp_host = GUARD && run_model == MAXRUN;
        checks++;
        if (host_gnt !== exp_host || disp_gnt !== !exp_host) begin
          errors++; $display("FAIL starve_gnt%0d disp=%b host=%b expected host=%b", ng, disp_gnt, host_gnt, exp_host);
        end
        if (host_gnt) nh++;
        run_model = next_run(run_model, exp_host);
        ng++;
      end
      tick(); settle(); c++;
    end
    disp_req = 1'b0; host_req = 1'b0;
    checks++;
    if (ng != 27 || nh != (GUARD ? 27 / (MAXRUN + 1) : 0)) begin
      errors++; $display("FAIL starve_count grants=%0d host=%0d expected 27 %0d", ng, nh, GUARD ? 27 / (MAXRUN + 1) : 0);
    end
    for (int i = 0; i < 2 * ACC + 4; i++) tick();
  endtask

  task automatic test_reset_mid();
    int spurious, lat;
    bit done;
    tick(); disp_req = 1'b1; disp_addr = 18'h00010; settle();
    checks++;
    if (disp_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b expected 1", disp_gnt); end
    tick(); Rst = 1'b1; host_req = 1'b1; host_we = 1'b0; settle();
    checks++;
    if (disp_gnt !== 1'b0 || host_gnt !== 1'b0) begin
      errors++; $display("FAIL rmid_rst_gnt disp=%b host=%b expected 0 0", disp_gnt, host_gnt);
    end
    tick(); Rst = 1'b0; disp_req = 1'b0; host_req = 1'b0; run_model = 0; settle();
    checks++;
    if ({SRAM_NCE, SRAM_NOE, SRAM_NWE} !== 3'b111 || SRAM_BE !== 2'b11 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL rmid_ctl ctl=%b be=%b oe=%b expected 111 11 0",
                         {SRAM_NCE, SRAM_NOE, SRAM_NWE}, SRAM_BE, sram_dq_oe);
    end
    spurious = 0;
    for (int i = 0; i < 5; i++) begin
      if (disp_rvalid || host_rvalid || host_wdone) spurious++;
      tick(); settle();
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL rmid_spurious got %0d expected 0", spurious); end
    disp_req = 1'b1; disp_addr = 18'h00010; settle();
    checks++;
    if (disp_gnt !== 1'b1) begin errors++; $display("FAIL rmid_fresh_gnt got %b expected 1", disp_gnt); end
    lat = 0; done = 1'b0;
    while (!done && lat < 4 * ACC + 4) begin
      tick(); disp_req = 1'b0; settle(); lat++;
      if (disp_rvalid) done = 1'b1;
    end
    checks++;
    if (!done || lat != ACC + 1 || disp_rdata !== 16'hA5C3) begin
      errors++; $display("FAIL rmid_fresh_read done=%b lat=%0d d=%h expected 1 %0d a5c3", done, lat, disp_rdata, ACC + 1);
    end
  endtask

  initial begin
    Rst = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_be = 2'b00;
    test_reset();
    test_disp_read();
    test_host_write();
    test_back_to_back();
    test_write_then_read();
    test_random();
    test_starve();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
- REQ-001 SHALL have parameters: ADDR_W, default 18, SRAM word-address width; DATA_W, default 16, SRAM data width; ACC_CYC, default 2, clocks per access (legal 1..15); MAX_DISP_RUN, default 8, consecutive display grants allowed before host priority under the guard.
- REQ-002 SHALL have ports: Clk  in  1  sole clock; Rst  in  1  synchronous active-high reset.
- REQ-003 SHALL have display read port: disp_req in 1 read request; disp_addr in ADDR_W address; disp_gnt out 1 request accepted; disp_rvalid out 1 read data valid; disp_rdata out DATA_W read data.
- REQ-004 SHALL have host port: host_req in 1 request; host_we in 1, 1=write; host_addr in ADDR_W address; host_wdata in DATA_W write data; host_be in 2 byte enables, active-high; host_gnt out 1 accepted; host_rvalid out 1 read data valid; host_rdata out DATA_W read data; host_wdone out 1 write complete.
- REQ-005 SHALL have SRAM side: SRAM_ADDR out ADDR_W; SRAM_BE out 2, active-low; SRAM_NCE, SRAM_NOE, SRAM_NWE out 1 each, active-low; sram_dq_out out DATA_W; sram_dq_oe out 1 tristate enable; sram_dq_in in DATA_W. The tristate buffer lives in the parent.

Function
- REQ-006 SHALL implement FSM states IDLE, RD, WR, TURN; all SRAM-side outputs registered.
- REQ-007 SHALL accept a request, asserting the matching gnt combinationally for one cycle, only in IDLE or in the final RD cycle; addr, we, wdata and be are captured at that edge.
- REQ-008 Requesters SHALL hold req and payload stable until gnt. A req still high in the cycle after gnt SHALL count as a new request.
- REQ-009 Priority SHALL be display over host when both requests are pending in the same accept cycle.
- REQ-010 SHALL, on an accepted read, enter RD and drive NCE=0, NOE=0, NWE=1, BE=00 (display) or ~host_be (host), and SRAM_ADDR for exactly ACC_CYC cycles, starting the cycle after gnt.
- REQ-011 SHALL sample sram_dq_in at the end of the final RD cycle and assert the owner's rvalid for one cycle in the next cycle, with rdata holding that value until the owner's next read.
- REQ-012 SHALL allow back-to-back reads: RD to RD with no idle cycle when a request is accepted in the final RD cycle.
- REQ-013 SHALL, on a host write, enter WR and drive NCE=0, NWE=0, NOE=1, BE=~host_be, dq_oe=1, and dq_out=wdata for ACC_CYC cycles, then enter TURN.
- REQ-014 TURN SHALL last one cycle with NCE=NOE=NWE=1 and dq_oe=0; host_wdone SHALL pulse in the TURN cycle; no grant is given in TURN.
- REQ-015 SHALL force NOE=1 whenever dq_oe=1, so the SRAM never drives the bus while the arbiter does.
- REQ-016 SHALL return to IDLE with NCE=1 when no request is accepted in the final RD cycle.
- REQ-017 SHALL ignore host_be during display reads; a host access with host_be=00 SHALL still run a full access cycle.

Reset
- REQ-018 Rst SHALL force, at the next edge: state IDLE; SRAM_ADDR=0; SRAM_BE=11; NCE=NOE=NWE=1; dq_oe=0; dq_out=0; all gnt, rvalid, and wdone=0; rdata=0; run counter=0.
- REQ-019 Rst asserted mid-access SHALL abort the access with no rvalid or wdone for it; in the Rst cycle gnt SHALL be 0 regardless of req.

Configuration
- REQ-020 With SRAM_ARB_STARVE_GUARD_EN defined, a saturating counter SHALL count consecutive display grants and clear on any host grant.
  - When it equals MAX_DISP_RUN and host_req is high, host SHALL win the next accept cycle.
- REQ-021 Without SRAM_ARB_STARVE_GUARD_EN, priority SHALL be strictly fixed (REQ-009) and no counter SHALL be synthesized.

Structure
- REQ-022 Package sram_arb_pkg SHALL hold the state enumeration, default ADDR_W/DATA_W/ACC_CYC constants, and the BE active-low inactive constant 2'b11.
- REQ-023 Sub-module sram_arb_sched SHALL contain the priority select and the starvation counter; the FSM, access counter and SRAM registers stay in sram_arbiter.

Verification
- REQ-024 Single display read, ACC_CYC=2, addr 0x00010, SRAM model returns 0xA5C3 -> disp_gnt cycle 0; NCE/NOE low cycles 1–2; disp_rvalid cycle 3 with 0xA5C3.
- REQ-025 Host write addr 0x3FFFF, data 0x1234, be=10 -> NWE low 2 cycles with BE=01 and dq_oe=1; TURN cycle with host_wdone; the model holds 0x12 in the upper byte only.
- REQ-026 disp_req and host_req both high continuously, guard defined, MAX_DISP_RUN=8 -> 8 display grants then 1 host grant, repeating; guard undefined -> host never granted.
- REQ-027 Host write immediately followed by display read request -> exactly one TURN cycle between the last NWE-low cycle and NOE low; never dq_oe=1 with NOE=0.
- REQ-028 Rst pulsed in the first RD cycle -> next cycle all controls are inactive, no rvalid, and a fresh request is granted normally afterwards.
